// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle FP adder.
// Operations with a zero operand bypass the adder; results wait in RESP for the consumer.
module fp_add_arbiter #(
    parameter int unsigned ADD_LAT = 3,
    parameter logic [5:0]  ADDF    = 6'b010111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] fpa_number1,
    output logic [31:0] fpa_number2,
    output logic [5:0]  fpa_opcode,
    input  logic [31:0] fpa_sum,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT = 4'(ADD_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;

    logic        in_idle;
    logic        handshake;
    logic        gnt_id;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    // Grant is gated by reset so ready drops immediately even though IDLE is the reset state.
    assign in_idle    = (state_q == IDLE) && !reset;
    assign req0_ready = in_idle && req0_valid && (!req1_valid || last_grant_q);
    assign req1_ready = in_idle && req1_valid && (!req0_valid || !last_grant_q);

    assign handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign gnt_id    = req1_ready;
    assign sel_a     = gnt_id ? req1_a : req0_a;
    assign sel_b     = gnt_id ? req1_b : req0_b;

    assign fpa_number1 = (state_q == WAIT) ? op_a_q : '0;
    assign fpa_number2 = (state_q == WAIT) ? op_b_q : '0;
    assign fpa_opcode  = (state_q == WAIT) ? ADDF : '0;
    assign rsp_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    last_grant_d = gnt_id;
                    rsp_id_d     = gnt_id;
                    op_a_d       = sel_a;
                    op_b_d       = sel_b;
                    // Signed zeros count as zero; when both are zero the A operand is returned.
                    if (sel_a[30:0] == '0 || sel_b[30:0] == '0) begin
                        rsp_data_d = (sel_b[30:0] == '0) ? sel_a : sel_b;
                        state_d    = RESP;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAT) begin
                    rsp_data_d = fpa_sum;
                    cnt_d      = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: default build plus an ADD_LAT=1 build,
// each with a small adder model that only returns a sum while ADDF is presented.
module tb_fp_add_arbiter;

    localparam logic [5:0] ADDF = 6'b010111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [31:0] fpa_number1, fpa_number2, fpa_sum, rsp_data;
    logic [5:0]  fpa_opcode;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] sum_val = '0;

    logic        d2_req0_valid = 1'b0;
    logic        d2_req0_ready, d2_req1_ready;
    logic [31:0] d2_number1, d2_number2, d2_sum, d2_rsp_data;
    logic [5:0]  d2_opcode;
    logic        d2_rsp_valid, d2_rsp_id, d2_busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    assign fpa_sum = (fpa_opcode == ADDF) ? sum_val : 32'hDEADBEEF;
    assign d2_sum  = (d2_opcode == ADDF) ? 32'h40400000 : 32'hDEADBEEF;

    fp_add_arbiter #(.ADD_LAT(3), .ADDF(ADDF)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .fpa_number1(fpa_number1), .fpa_number2(fpa_number2),
        .fpa_opcode(fpa_opcode), .fpa_sum(fpa_sum),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    fp_add_arbiter #(.ADD_LAT(1), .ADDF(ADDF)) dut2 (
        .clk(clk), .reset(reset),
        .req0_valid(d2_req0_valid), .req1_valid(1'b0),
        .req0_ready(d2_req0_ready), .req1_ready(d2_req1_ready),
        .req0_a(32'h3F800000), .req0_b(32'h40000000),
        .req1_a(32'h0), .req1_b(32'h0),
        .fpa_number1(d2_number1), .fpa_number2(d2_number2),
        .fpa_opcode(d2_opcode), .fpa_sum(d2_sum),
        .rsp_valid(d2_rsp_valid), .rsp_ready(1'b1),
        .rsp_id(d2_rsp_id), .rsp_data(d2_rsp_data), .busy(d2_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_bypass(input logic id, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        chk("byp_ready", id ? req1_ready : req0_ready, 1);
        chk("byp_op_c0", fpa_opcode, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("byp_rsp_valid", rsp_valid, 1);
        chk("byp_rsp_data", rsp_data, exp);
        chk("byp_rsp_id", rsp_id, id);
        chk("byp_op_c1", fpa_opcode, 0);
        tick();
        chk("byp_idle", busy, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_opcode", fpa_opcode, 0);
        chk("rst_data", rsp_data, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // Single add on req0
        sum_val = 32'h40400000;
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        #1;
        chk("t1_r0_ready", req0_ready, 1);
        chk("t1_r1_ready", req1_ready, 0);
        chk("t1_op_c0", fpa_opcode, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            chk("t1_op_wait", fpa_opcode, ADDF);
            chk("t1_num1", fpa_number1, 32'h3F800000);
            chk("t1_num2", fpa_number2, 32'h40000000);
            chk("t1_no_rsp", rsp_valid, 0);
            chk("t1_busy", busy, 1);
            tick();
        end
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, 32'h40400000);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_op_resp", fpa_opcode, 0);
        tick();
        chk("t1_back_idle", rsp_valid, 0);

        // Tie after reset: alternating grants, 5 cycles apart
        reset = 1'b1; #1; reset = 1'b0;
        sum_val = 32'h41100000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 32'h40800000; req1_b = 32'h40A00000;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("tie_r0_ready", req0_ready, (g % 2) == 0);
            chk("tie_r1_ready", req1_ready, (g % 2) == 1);
            tick();
            for (int c = 1; c <= 3; c++) begin
                chk("tie_no_grant", {req0_ready, req1_ready}, 0);
                chk("tie_num1", fpa_number1, (g % 2) ? 32'h40800000 : 32'h3F800000);
                tick();
            end
            chk("tie_rsp_valid", rsp_valid, 1);
            chk("tie_rsp_id", rsp_id, g % 2);
            chk("tie_resp_no_grant", {req0_ready, req1_ready}, 0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("tie_dropped", busy, 0);

        // Zero bypass cases
        run_bypass(1'b1, 32'h00000000, 32'hC0A00000, 32'hC0A00000);
        run_bypass(1'b0, 32'h41200000, 32'h80000000, 32'h41200000);
        run_bypass(1'b0, 32'h80000000, 32'h00000000, 32'h80000000);

        // Backpressure with req1 waiting
        rsp_ready = 1'b0; sum_val = 32'h40400000;
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        #1;
        chk("bp_r0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h40800000; req1_b = 32'h40A00000;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'h40400000);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_r1_ready", req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_r1_ready_last", req1_ready, 0);
        tick();
        chk("bp_r1_granted", req1_ready, 1);
        chk("bp_idle", rsp_valid, 0);
        sum_val = 32'h41100000;
        tick();
        req1_valid = 1'b0;
        tick(); tick(); tick();
        chk("bp2_rsp_data", rsp_data, 32'h41100000);
        chk("bp2_rsp_id", rsp_id, 1);
        tick();

        // Reset in WAIT at cnt=2
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        tick();
        req0_valid = 1'b0;
        tick();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_opcode", fpa_opcode, 0);
        chk("mr_num1", fpa_number1, 0);
        chk("mr_num2", fpa_number2, 0);
        chk("mr_ready", {req0_ready, req1_ready}, 0);
        chk("mr_data", rsp_data, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mr_no_rsp", {rsp_valid, busy}, 0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mr_tie_r0", req0_ready, 1);
        chk("mr_tie_r1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // ADD_LAT=1 build
        d2_req0_valid = 1'b1;
        #1;
        chk("l1_ready", d2_req0_ready, 1);
        chk("l1_op_c0", d2_opcode, 0);
        tick();
        d2_req0_valid = 1'b0;
        chk("l1_op_c1", d2_opcode, ADDF);
        chk("l1_no_rsp", d2_rsp_valid, 0);
        tick();
        chk("l1_op_c2", d2_opcode, 0);
        chk("l1_rsp_valid", d2_rsp_valid, 1);
        chk("l1_rsp_data", d2_rsp_data, 32'h40400000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter ADD_LAT, default 3: cycles the shared adder's operands and opcode are held before the sum is sampled; legal range 1..15.
REQ-002 The block SHALL have parameter ADDF, default 6'b010111: the opcode that triggers the shared adder.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester N presents an add.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: grant to requester N; the handshake completes when valid and ready are both high at a clock edge.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-008 The block SHALL have ports fpa_number1, fpa_number2, output, 32 bits each: operands driven to the shared adder.
REQ-009 The block SHALL have port fpa_opcode, output, 6 bits: opcode driven to the shared adder.
REQ-010 The block SHALL have port fpa_sum, input, 32 bits: result returned by the shared adder.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-014 The block SHALL have port rsp_data, output, 32 bits: the result.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL use a 4-bit counter cnt.
REQ-017 In IDLE, exactly one reqN_ready SHALL be high when at least one requester is valid, and none otherwise; ready depends only on state, valid and last_grant.
REQ-018 When only one requester is valid, that requester SHALL be granted.
REQ-019 When both requesters are valid, the requester not equal to last_grant SHALL be granted (round-robin).
REQ-020 last_grant SHALL update to the granted index on each handshake.
REQ-021 On a handshake, the granted operands SHALL be latched into opA/opB, and the granted index SHALL be latched into rsp_id.
REQ-022 Zero bypass: if either latched operand has bits[30:0]==0, the FSM SHALL go to RESP next cycle, and rsp_data SHALL be the other operand (opA if both are zero); the adder is not triggered.
REQ-023 Otherwise the FSM SHALL go to WAIT with cnt=1.
REQ-024 In WAIT, fpa_number1=opA, fpa_number2=opB and fpa_opcode=ADDF SHALL hold every cycle.
REQ-025 In every state other than WAIT, fpa_opcode SHALL be 6'b0, so each operation presents a fresh 0->ADDF transition.
REQ-026 In WAIT, cnt SHALL increment each cycle; when cnt==ADD_LAT, fpa_sum SHALL be captured into rsp_data and the FSM SHALL go to RESP.
REQ-027 Latency SHALL be ADD_LAT+1 cycles from the handshake edge to rsp_valid high in the adder path, and 1 cycle in the bypass path.
REQ-028 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be stable until rsp_ready.
REQ-029 On rsp_valid & rsp_ready, the FSM SHALL go to IDLE; the next grant can occur in the following cycle, with no grant in RESP.
REQ-030 No reqN_ready SHALL be high outside IDLE; requests arriving in WAIT or RESP wait and are not dropped.
REQ-031 A requester dropping valid before its handshake SHALL have no effect; there is no hold obligation on the requester.

Reset
REQ-032 Asserting reset SHALL immediately (asynchronously) set: state=IDLE, cnt=0, last_grant=1 (so req0 wins the first tie), opA=opB=0, rsp_data=0, rsp_id=0.
REQ-033 Asserting reset SHALL immediately (asynchronously) drive: rsp_valid=0, busy=0, req0_ready=req1_ready=0, fpa_opcode=0, fpa_number1=fpa_number2=0.
REQ-034 Reset in WAIT or RESP SHALL abandon the operation; no response is produced after reset releases.

Verification
REQ-035 Single add: req0 only, a=0x3F800000, b=0x40000000, adder model returns 0x40400000 -> req0_ready in cycle 0; fpa_opcode=ADDF for 3 cycles; rsp_valid in cycle 4 with rsp_data=0x40400000, rsp_id=0.
REQ-036 Tie after reset: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; handshakes spaced 5 cycles apart.
REQ-037 Zero bypass: req1 a=0x00000000, b=0xC0A00000 -> rsp_valid 1 cycle after the handshake, rsp_data=0xC0A00000, rsp_id=1, fpa_opcode stays 0 throughout.
REQ-038 Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; req1_valid held high and req1_ready=0 until the cycle after rsp_ready=1.
REQ-039 Reset mid-WAIT: assert reset at cnt=2 -> all outputs zero immediately; after release, IDLE with no rsp_valid; the next tie grants req0.
REQ-040 ADD_LAT=1 build: single add -> fpa_opcode=ADDF for exactly 1 cycle; rsp_valid 2 cycles after the handshake.
